// File: rtl/angstrom_pkg.sv
// rtl/angstrom_pkg.sv - shared widths, reset PC and fetch state type
package angstrom_pkg;
    localparam int ADDR_W   = 12;
    localparam int NIBBLE_W = 4;
    localparam int INSTR_W  = 16;
    localparam int NIBBLES  = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/nibble_assembler.sv
// rtl/nibble_assembler.sv - shifts nibbles into an instruction word and flags the last one
module nibble_assembler
    import angstrom_pkg::*;
#(
    parameter int NIBBLE_W_P = NIBBLE_W,
    parameter int NIBBLES_P  = NIBBLES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr_i,
    input  logic                            en_i,
    input  logic [NIBBLE_W_P-1:0]           nibble_i,
    output logic [NIBBLE_W_P*NIBBLES_P-1:0] word_o,
    output logic                            done_o
);
    localparam int W     = NIBBLE_W_P * NIBBLES_P;
    localparam int CNT_W = $clog2(NIBBLES_P);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES_P - 1);

    logic [W-1:0]     shift_q;
    logic [CNT_W-1:0] cnt_q;

    // Word includes the nibble arriving this cycle so the top can capture it on done.
    assign word_o = {shift_q[W-NIBBLE_W_P-1:0], nibble_i};
    assign done_o = en_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr_i) begin
            cnt_q   <= '0;
        end else if (en_i) begin
            shift_q <= word_o;
            cnt_q   <= done_o ? '0 : cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - nibble-serial instruction fetch with PC, jump redirect and valid/ready output
module fetch_unit
    import angstrom_pkg::*;
#(
    parameter int                 ADDR_W_P   = ADDR_W,
    parameter int                 NIBBLE_W_P = NIBBLE_W,
    parameter int                 NIBBLES_P  = NIBBLES,
    parameter logic [ADDR_W_P-1:0] RESET_PC_P = RESET_PC
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    output logic [ADDR_W_P-1:0]            ramAddr,
    output logic                           ramReadEn,
    input  logic [NIBBLE_W_P-1:0]          ramDout,
    output logic [NIBBLE_W_P*NIBBLES_P-1:0] instr,
    output logic                           instrValid,
    input  logic                           instrReady,
    output logic [ADDR_W_P-1:0]            pc,
    input  logic                           jumpEn,
    input  logic [ADDR_W_P-1:0]            jumpAddr
);
    localparam int IW = NIBBLE_W_P * NIBBLES_P;

    fetch_state_e         state_q, state_d;
    logic [ADDR_W_P-1:0]  fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W_P-1:0]  pc_q, pc_d;
    logic [IW-1:0]        instr_q, instr_d;
    logic [IW-1:0]        asm_word;
    logic                 asm_done;
    logic                 fetch_en;
    logic                 handshake;

    // Jump overrides any progress this cycle, including the assembler step.
    assign fetch_en  = (state_q == FETCH) && !jumpEn;
    assign handshake = (state_q == VALID) && instrReady;

    nibble_assembler #(
        .NIBBLE_W_P (NIBBLE_W_P),
        .NIBBLES_P  (NIBBLES_P)
    ) u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (jumpEn),
        .en_i     (fetch_en),
        .nibble_i (ramDout),
        .word_o   (asm_word),
        .done_o   (asm_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (jumpEn) begin
            state_d = run ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (run) state_d = FETCH;
                FETCH:   if (asm_done) state_d = VALID;
                VALID:   if (instrReady) state_d = run ? FETCH : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ramReadEn  = (state_q == FETCH);
        instrValid = (state_q == VALID);
    end

    always_comb begin
        fetch_ptr_d = fetch_ptr_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        if (jumpEn) begin
            fetch_ptr_d = jumpAddr;
            pc_d        = jumpAddr;
        end else begin
            if (fetch_en)  fetch_ptr_d = fetch_ptr_q + ADDR_W_P'(1);
            if (asm_done)  instr_d     = asm_word;
            if (handshake) pc_d        = fetch_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_ptr_q <= RESET_PC_P;
            pc_q        <= RESET_PC_P;
            instr_q     <= '0;
        end else begin
            fetch_ptr_q <= fetch_ptr_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
        end
    end

    assign ramAddr = fetch_ptr_q;
    assign pc      = pc_q;
    assign instr   = instr_q;
endmodule
